// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/sub whose carry chain is cut into STAGES registered segments,
// with a valid/ready handshake and a global stall on backpressure.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH) begin : g_bad
        $fatal(1, "pipelined_addsub: need WIDTH >= 2 and 1 <= STAGES <= WIDTH");
    end

    logic stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * CHUNK;
        localparam int HI = ((k + 1) * CHUNK < WIDTH ? (k + 1) * CHUNK : WIDTH) - 1;
        logic          v, c, pv, pc, nc;
        logic [HI:0]   rs, ns;

        if (k == 0) begin : g_src
            assign pv = in_valid;
            assign pc = sub;
        end else begin : g_src
            assign pv = g_st[k-1].v;
            assign pc = g_st[k-1].c;
        end

        // A segment past the top bit (possible when CHUNK rounds up) just forwards its input.
        if (LO < WIDTH) begin : g_add
            localparam int N = HI - LO + 1;
            logic [WIDTH-1:LO] pa, pb;
            logic              psub;
            logic [N:0]        sum;
            if (k == 0) begin : g_op
                assign pa   = a;
                assign pb   = b;
                assign psub = sub;
                assign ns   = sum[N-1:0];
            end else begin : g_op
                assign pa   = g_st[k-1].g_more.ra;
                assign pb   = g_st[k-1].g_more.rb;
                assign psub = g_st[k-1].g_more.rsub;
                assign ns   = {sum[N-1:0], g_st[k-1].rs};
            end
            assign sum = {1'b0, pa[HI:LO]} + {1'b0, pb[HI:LO] ^ {N{psub}}} + {{N{1'b0}}, pc};
            assign nc  = sum[N];
        end else begin : g_pass
            assign ns = g_st[k-1].rs;
            assign nc = pc;
        end

        if (HI < WIDTH - 1) begin : g_more
            logic [WIDTH-1:HI+1] ra, rb;
            logic                rsub;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ra   <= '0;
                    rb   <= '0;
                    rsub <= 1'b0;
                end else if (!stall) begin
                    ra   <= g_add.pa[WIDTH-1:HI+1];
                    rb   <= g_add.pb[WIDTH-1:HI+1];
                    rsub <= g_add.psub;
                end
            end
        end else begin : g_msb
            // Carry into the top bit, recovered from its sum bit, kept for the overflow flag.
            logic rm, nm;
            if (LO < WIDTH) begin : g_cin
                assign nm = g_add.pa[WIDTH-1] ^ g_add.pb[WIDTH-1] ^ g_add.psub ^ g_add.sum[HI-LO];
            end else begin : g_cin
                assign nm = g_st[k-1].g_msb.rm;
            end
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) rm <= 1'b0;
                else if (!stall) rm <= nm;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v  <= 1'b0;
                c  <= 1'b0;
                rs <= '0;
            end else if (!stall) begin
                v  <= pv;
                c  <= nc;
                rs <= ns;
            end
        end
    end

    assign stall     = g_st[STAGES-1].v && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = g_st[STAGES-1].v;
    assign s         = g_st[STAGES-1].rs;
    assign cout      = g_st[STAGES-1].c;
    assign ovf       = g_st[STAGES-1].g_msb.rm ^ g_st[STAGES-1].c;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench; drivers push expected results at acceptance,
// monitors pop and compare whenever a result is consumed.
module tb_pipelined_addsub;
    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          t;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic sw_or;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m_iv, m_ir, m_sub, m_ov, m_or, m_c, m_o;
    logic [15:0] m_a, m_b, m_s;
    exp_t        m_exp, m_e;
    exp_t        mq[$];
    bit          bp, run, stalled;
    logic [31:0] held;

    pipelined_addsub #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .reset(reset), .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b),
        .sub(m_sub), .out_valid(m_ov), .out_ready(m_or), .s(m_s), .cout(m_c), .ovf(m_o)
    );

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", n, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
        exp_t e;
        e.s = s; e.c = c; e.o = o; e.t = 0; e.lat = 1'b0;
        return e;
    endfunction

    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic sb);
        exp_t        e;
        logic [16:0] r;
        logic [15:0] m, bx;
        logic [3:0]  mi;
        mi = 4'(w - 1);
        m  = 16'((17'h1 << w) - 17'h1);
        bx = (sb ? ~b : b) & m;
        r  = {1'b0, a & m} + {1'b0, bx} + {16'b0, sb};
        e.s = r[15:0] & m;
        e.c = r[5'(w)];
        e.o = (a[mi] == bx[mi]) && (e.s[mi] != a[mi]);
        e.t = 0; e.lat = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) stalled = 1'b0;
        else begin
            check("in_ready", 32'(m_ir), 32'(!(m_ov && !m_or)));
            if (stalled) check("hold", {14'b0, m_c, m_o, m_s}, held);
            stalled = m_ov && !m_or;
            held = {14'b0, m_c, m_o, m_s};
            if (m_iv && m_ir) begin
                m_e = m_exp; m_e.t = cyc; m_e.lat = !bp;
                mq.push_back(m_e);
            end
            if (m_ov && m_or) begin
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious: got s=0x%0h, want no result", m_s);
                end else begin
                    m_e = mq.pop_front();
                    check("sum", 32'(m_s), 32'(m_e.s));
                    check("cout", 32'(m_c), 32'(m_e.c));
                    check("ovf", 32'(m_o), 32'(m_e.o));
                    if (m_e.lat) check("latency", 32'(cyc - m_e.t), 32'(2));
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sb, input exp_t e);
        int n = 0;
        bit acc = 1'b0;
        m_a = a; m_b = b; m_sub = sb; m_exp = e; m_iv = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = m_ir;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, want 1");
        end
    endtask

    task automatic drain();
        int n = 0;
        m_iv = 1'b0;
        while (mq.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding, want 0", mq.size());
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int W = g == 2 ? 13 : 8;
        localparam int S = g == 0 ? 1 : (g == 1 ? 8 : 3);
        localparam logic [W-1:0] MX = '1;
        localparam logic [W-1:0] MN = {1'b1, {(W-1){1'b0}}};
        localparam logic [W-1:0] MP = {1'b0, {(W-1){1'b1}}};
        logic [W-1:0] a, b, s;
        logic [W-1:0] va[7], vb[7];
        logic         vs[7];
        logic         sb, iv, ir, ov, c, o;
        bit           done;
        exp_t         ex, me;
        exp_t         q[$];

        pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
            .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
            .sub(sb), .out_valid(ov), .out_ready(sw_or), .s(s), .cout(c), .ovf(o)
        );

        always @(negedge clk) begin
            if (reset) begin
                check("sw_in_ready", 32'(ir), 32'(1));
                if (iv && ir) begin
                    me = ex; me.t = cyc;
                    q.push_back(me);
                end
                if (ov) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sw%0d_spurious: got s=0x%0h, want no result", g, s);
                    end else begin
                        me = q.pop_front();
                        check("sw_sum", 32'(s), 32'(me.s));
                        check("sw_cout", 32'(c), 32'(me.c));
                        check("sw_ovf", 32'(o), 32'(me.o));
                        check("sw_latency", 32'(cyc - me.t), 32'(S));
                    end
                end
            end
        end

        initial begin
            int n;
            done = 1'b0; iv = 1'b0; a = '0; b = '0; sb = 1'b0;
            va = '{MX, MX, MP, MN, W'(0), W'(0), MP};
            vb = '{W'(1), MX, W'(1), W'(1), W'(1), W'(0), MX};
            vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            wait (reset === 1'b1);
            @(posedge clk); #1;
            for (int i = 0; i < 27; i++) begin
                if (i < 7) begin
                    a = va[i]; b = vb[i]; sb = vs[i];
                end else begin
                    a = W'($urandom); b = W'($urandom); sb = 1'($urandom);
                end
                ex = model(W, 16'(a), 16'(b), sb);
                iv = 1'b1;
                @(posedge clk); #1;
            end
            iv = 1'b0;
            n = 0;
            while (q.size() != 0 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check("sw_drain", 32'(q.size()), 32'(0));
            done = 1'b1;
        end
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rsb;
        int          n;
        sw_or = 1'b1;
        m_iv = 1'b0; m_or = 1'b1; m_a = '0; m_b = '0; m_sub = 1'b0;
        m_exp = mk(16'h0, 1'b0, 1'b0);
        bp = 1'b0; run = 1'b0; reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(m_ov), 32'(0));
        check("rst_s", 32'(m_s), 32'(0));
        check("rst_cout", 32'(m_c), 32'(0));
        check("rst_ovf", 32'(m_o), 32'(0));
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(m_ir), 32'(1));
        @(posedge clk); #1;

        send(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        send(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        send(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        send(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        drain();

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rsb = 1'($urandom);
            send(ra, rb, rsb, model(16, ra, rb, rsb));
        end
        drain();

        bp = 1'b1; run = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    if ($urandom_range(1) == 1) begin
                        m_iv = 1'b0;
                        @(posedge clk); #1;
                    end
                    ra = 16'($urandom); rb = 16'($urandom); rsb = 1'($urandom);
                    send(ra, rb, rsb, model(16, ra, rb, rsb));
                end
                m_iv = 1'b0;
                run = 1'b0;
            end
            begin
                while (run) begin
                    @(posedge clk); #1;
                    m_or = 1'($urandom_range(1));
                end
            end
        join
        m_or = 1'b1;
        drain();
        bp = 1'b0;

        n = 0;
        while (!(sw[0].done && sw[1].done && sw[2].done) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("sweeps_done", {29'b0, sw[2].done, sw[1].done, sw[0].done}, 32'h7);

        send(16'h0003, 16'h0000, 1'b0, mk(16'h0003, 1'b0, 1'b0));
        send(16'h0004, 16'h0004, 1'b0, mk(16'h0008, 1'b0, 1'b0));
        m_iv = 1'b0;
        #2;
        reset = 1'b0;
        mq.delete();
        #1;
        check("midrst_out_valid", 32'(m_ov), 32'(0));
        check("midrst_s", 32'(m_s), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 32'(m_ir), 32'(1));
        repeat (8) @(posedge clk);
        #1;
        send(16'h1234, 16'h0234, 1'b1, mk(16'h1000, 1'b1, 1'b0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined N-bit adder/subtractor. It is the successor to the fixed 8-bit registered adder. The carry chain is split into STAGES register-separated segments so WIDTH scales without lengthening the critical path. It adds a per-transaction add/subtract mode, a signed-overflow flag and a valid/ready handshake with backpressure, and it sits between an upstream operand producer and a downstream result consumer in the sequential datapath designs.

Parameters:
WIDTH, 16, operand and sum width in bits; legal range ≥2.
STAGES, 2, number of pipeline register stages = carry segments; legal range 1..WIDTH. Elaboration fails outside this range.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset. Asserted when 0; it asserts immediately and releases synchronously to clk.
in_valid  input  1  operands a, b, sub are valid this cycle.
in_ready  output  1  the block accepts operands this cycle.
a  input  WIDTH  operand A (two's complement or unsigned).
b  input  WIDTH  operand B.
sub  input  1  0: s = a + b; 1: s = a - b (computed as a + ~b + 1).
out_valid  output  1  s, cout and ovf are valid.
out_ready  input  1  the consumer takes the result this cycle.
s  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  carry out of the MSB. For subtraction it is the inverted borrow: 1 means a >= b unsigned.
ovf  output  1  signed overflow = carry into the MSB XOR carry out of the MSB.

Behaviour:
- Reset (reset=0): all stage valid bits cleared, so out_valid=0. s=0, cout=0, ovf=0. in_ready=1 in the first cycle after release. Operand/partial-sum registers are cleared to 0.
- Segmentation: CHUNK = ceil(WIDTH/STAGES). Stage k (k=0..STAGES-1) adds bits [k*CHUNK, min((k+1)*CHUNK, WIDTH)-1]. The last segment may be narrower.
- Stage 0 carry-in is sub. Every stage uses b XOR {WIDTH{sub}}.
- Each stage registers:
  - its completed sum bits;
  - its carry-out;
  - the not-yet-added upper a/b bits;
  - the sub bit;
  - a valid bit.
- ovf is taken from the carry into and out of bit WIDTH-1 in the final segment.
- Transfer: an input is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Global-stall pipeline: stall = out_valid && !out_ready.
  - When stall=1, every stage register holds, including its valid bit.
  - in_ready = !stall, which is combinational from out_ready and the last-stage valid.
- When not stalled, every stage advances one position each cycle. Bubbles (valid=0) advance like data and are not collapsed.
- Latency: a result appears on out_valid exactly STAGES cycles after acceptance, given no stall in between. Throughput is one transaction per cycle while out_ready=1.
- s, cout and ovf change only on an advance. They are held stable while out_valid=1 and out_ready=0.
- Data on a bubble output is don't-care, but the registers still shift.
- Ordering: results leave in acceptance order. Nothing is dropped or duplicated under any in_valid/out_ready pattern.
- Simultaneous accept and consume in the same cycle is legal. Pipeline occupancy is unchanged.
- Reset mid-operation: all in-flight transactions are discarded. out_valid drops in the same cycle reset asserts, with no clock needed.
- STAGES=1: the block is a single registered adder with handshake, latency 1.
- STAGES=WIDTH: one bit per stage, i.e. a fully bit-pipelined ripple adder.
- Arithmetic: the full-precision unsigned sum equals {cout, s} for add. For sub it equals a + ~b + 1 in the same form.

Test Plan:
1. WIDTH=16, STAGES=2, out_ready=1: a=0xFFFF, b=0x0001, sub=0, accepted at cycle 0 → cycle 2: out_valid=1, s=0x0000, cout=1, ovf=0.
2. a=0x7FFF, b=0x0001, sub=0 → s=0x8000, cout=0, ovf=1. Then a=0x0005, b=0x0007, sub=1 → s=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → s=0x7FFF, cout=1, ovf=1.
3. Back-to-back stream of 20 random (a, b, sub) pairs with out_ready=1 → 20 results in consecutive cycles, in order, each matching the reference model.
4. Backpressure: stream 10 transactions while out_ready toggles pseudo-randomly (50%) and in_valid toggles independently. Check three things:
   - in_ready=0 exactly when out_valid && !out_ready;
   - outputs are stable while stalled;
   - all 10 results arrive in order with no loss or duplication.
5. Reset mid-stream: with 2 transactions in flight, drive reset=0 between clock edges → out_valid=0, s=0 immediately. After release, in_ready=1 and no stale result ever appears.
6. Parameter sweep with random vs. model checks, including the ovf and cout boundaries (0x00/0xFF, 0x80/0x7F):
   - WIDTH=8, STAGES=1: latency 1.
   - WIDTH=8, STAGES=8: latency 8.
   - WIDTH=13, STAGES=3: uneven chunks 5/5/3, latency 3.
